// File: rtl/commit_unit.sv
// rtl/commit_unit.sv - in-order ROB retirement stage; optional perf counters under COMMIT_PERF_CNT_EN
module commit_unit #(
  parameter  int ROBsize        = 16,
  parameter  int RESTORE_CYCLES = 2,
  localparam int TW             = $clog2(ROBsize) + 1
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          robValid_i,
  input  logic [78:0]   robEntry_i,
  input  logic [TW-1:0] robHead_i,
  input  logic [63:0]   redirectPc_i,
  input  logic          storeReady_i,
  output logic          updateHead_o,
  output logic          needToRestore_o,
  output logic          redirectValid_o,
  output logic [63:0]   redirectPc_o,
  output logic          regWriteEn_o,
  output logic [4:0]    regWriteAddr_o,
  output logic [63:0]   regWriteData_o,
  output logic [TW-1:0] regWriteTag_o,
  output logic          storeValid_o,
  output logic [TW-1:0] storeTag_o
`ifdef COMMIT_PERF_CNT_EN
  ,
  output logic [63:0]   perfRetired_o,
  output logic [31:0]   perfFlushes_o
`endif
);

  typedef enum logic [1:0] {S_RUN, S_STORE_WAIT, S_RESTORE} state_t;

  localparam int            CW      = (RESTORE_CYCLES > 1) ? $clog2(RESTORE_CYCLES) : 1;
  localparam logic [CW-1:0] RC_LAST = CW'(RESTORE_CYCLES - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_rst_cnt;

  logic       w_commitable;
  logic       w_mispredict;
  logic       w_mem_write;
  logic       w_reg_write;
  logic [4:0] w_rd;
  logic       w_flush_pop;
  logic       w_unused_reserved;

  assign w_rd              = robEntry_i[68:64];
  assign w_reg_write       = robEntry_i[69];
  assign w_mem_write       = robEntry_i[70];
  assign w_mispredict      = robEntry_i[71];
  assign w_commitable      = robValid_i & robEntry_i[72];
  assign w_unused_reserved = ^robEntry_i[78:73];
  // A committed mispredict always pops, even if it also carries a store
  assign w_flush_pop       = (r_state == S_RUN) & w_commitable & w_mispredict;

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= S_RUN;
    else            r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RUN: begin
        if (w_commitable) begin
          if (w_mispredict)     w_next_state = S_RESTORE;
          else if (w_mem_write) w_next_state = S_STORE_WAIT;
        end
      end
      S_STORE_WAIT: if (storeReady_i) w_next_state = S_RUN;
      S_RESTORE:    if (r_rst_cnt == '0) w_next_state = S_RUN;
      default:      w_next_state = S_RUN;
    endcase
  end

  // Pop decision: stores pop only once the store buffer takes them
  always_comb begin
    updateHead_o = 1'b0;
    case (r_state)
      S_RUN:        updateHead_o = w_commitable & (w_mispredict | ~w_mem_write);
      S_STORE_WAIT: updateHead_o = storeReady_i;
      default:      updateHead_o = 1'b0;
    endcase
  end

  // Restore window countdown, loaded when the mispredict pops
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                                   r_rst_cnt <= '0;
    else if (w_flush_pop)                             r_rst_cnt <= RC_LAST;
    else if (r_state == S_RESTORE && r_rst_cnt != '0) r_rst_cnt <= r_rst_cnt - CW'(1);
  end

  // Registered flush, redirect, store-offer and RF-write outputs
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      needToRestore_o <= 1'b0;
      redirectValid_o <= 1'b0;
      redirectPc_o    <= '0;
      storeValid_o    <= 1'b0;
      storeTag_o      <= '0;
      regWriteEn_o    <= 1'b0;
      regWriteAddr_o  <= '0;
      regWriteData_o  <= '0;
      regWriteTag_o   <= '0;
    end else begin
      needToRestore_o <= (w_next_state == S_RESTORE);
      redirectValid_o <= w_flush_pop;
      if (w_flush_pop) redirectPc_o <= redirectPc_i;
      storeValid_o    <= (w_next_state == S_STORE_WAIT);
      if (r_state == S_RUN && w_next_state == S_STORE_WAIT) storeTag_o <= robHead_i;
      regWriteEn_o    <= updateHead_o & w_reg_write & (w_rd != 5'd0);
      if (updateHead_o) begin
        regWriteAddr_o <= w_rd;
        regWriteData_o <= robEntry_i[63:0];
        regWriteTag_o  <= robHead_i;
      end
    end
  end

`ifdef COMMIT_PERF_CNT_EN
  // Free-running retire and flush counters, wrapping naturally
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      perfRetired_o <= '0;
      perfFlushes_o <= '0;
    end else begin
      if (updateHead_o) perfRetired_o <= perfRetired_o + 64'd1;
      if (w_flush_pop)  perfFlushes_o <= perfFlushes_o + 32'd1;
    end
  end
`endif

endmodule
